// File: rtl/input_conditioner_if.sv
// Pin-side bundle for the input conditioner: raw inputs in, conditioned levels and pulses out.
interface input_conditioner_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] edge_pulse;

    // Drives the raw inputs and consumes the conditioned results.
    modport master (
        output async_in,
        input  sync_out,
        input  debounced,
        input  edge_pulse
    );

    // The conditioner itself.
    modport slave (
        input  async_in,
        output sync_out,
        output debounced,
        output edge_pulse
    );
endinterface

// File: rtl/input_conditioner.sv
// Multi-channel synchronizer + sampled debouncer + edge detector.
// One shared sample-tick counter; each channel is an independent lane instance.

module input_conditioner_lane #(
    parameter int SYNC_STAGES   = 2,
    parameter int PULSE_CNT_MAX = 200,
    parameter int EDGE_MODE     = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic async_bit,
    output logic sync_bit,
    output logic deb_bit,
    output logic edge_bit
);
    localparam int CW = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(PULSE_CNT_MAX);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   prev_q, prev_d;
    logic                   rise, fall;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign deb_bit  = (cnt_q == CNT_SAT);
    assign rise     = deb_bit & ~prev_q;
    assign fall     = ~deb_bit & prev_q;

    // Plain shift chain: bit 0 captures the pin, the top bit is the synchronized level.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_bit};
    end

    // Stability counter: any low cycle clears it (clear beats tick), ticks count up to saturation.
    always_comb begin
        cnt_d = cnt_q;
        if (!sync_bit) begin
            cnt_d = '0;
        end else if (tick && (cnt_q < CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // History of the debounced level for edge detection.
    always_comb begin
        prev_d = deb_bit;
    end

    // Edge selection; unknown modes fall back to rising edges.
    always_comb begin
        case (EDGE_MODE)
            1:       edge_bit = fall;
            2:       edge_bit = rise | fall;
            default: edge_bit = rise;
        endcase
    end

    // Lane state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            prev_q <= prev_d;
        end
    end
endmodule

module input_conditioner #(
    parameter int WIDTH          = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_CNT_MAX = 62500,
    parameter int PULSE_CNT_MAX  = 200,
    parameter int EDGE_MODE      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input_conditioner_if.slave    io
);
    localparam int SW = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLE_CNT_MAX - 1);

    generate
        if (SYNC_STAGES < 2)    begin : g_bad_sync  $error("SYNC_STAGES must be >= 2");    end
        if (SAMPLE_CNT_MAX < 1) begin : g_bad_smp   $error("SAMPLE_CNT_MAX must be >= 1"); end
        if (PULSE_CNT_MAX < 1)  begin : g_bad_pulse $error("PULSE_CNT_MAX must be >= 1");  end
    endgenerate

    logic [SW-1:0]    smp_q, smp_d;
    logic             tick;
    logic [WIDTH-1:0] sync_w, deb_w, edge_w;

    // Tick on the last count of each sample interval; with a single-cycle interval it is always high.
    assign tick = (smp_q == SMP_LAST);

    // Free-running sample counter shared by all channels.
    always_comb begin
        smp_d = tick ? '0 : smp_q + 1'b1;
    end

    // Sample counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q <= '0;
        end else begin
            smp_q <= smp_d;
        end
    end

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_lane
            input_conditioner_lane #(
                .SYNC_STAGES   (SYNC_STAGES),
                .PULSE_CNT_MAX (PULSE_CNT_MAX),
                .EDGE_MODE     (EDGE_MODE)
            ) u_lane (
                .clk       (clk),
                .rst_n     (rst_n),
                .tick      (tick),
                .async_bit (io.async_in[i]),
                .sync_bit  (sync_w[i]),
                .deb_bit   (deb_w[i]),
                .edge_bit  (edge_w[i])
            );
        end
    endgenerate

    assign io.sync_out   = sync_w;
    assign io.debounced  = deb_w;
    assign io.edge_pulse = edge_w;
endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Parametrised multi-channel front end for asynchronous inputs such as buttons and switches.
- Each channel passes through an N-stage synchronizer, then a sampled debouncer. A configurable edge detector follows the debouncer.
- Sits between board I/O pins and the core/MMIO logic, and replaces ad-hoc per-button sync/debounce chains.
- All channels share one sample-tick counter.

Parameters:
- WIDTH, 1, number of independent input channels.
- SYNC_STAGES, 2, flip-flops per synchronizer chain; must be >= 2.
- SAMPLE_CNT_MAX, 62500, clock cycles per debounce sample tick; must be >= 1.
- PULSE_CNT_MAX, 200, consecutive high samples required before a channel is declared stable; must be >= 1.
- EDGE_MODE, 0, edge_pulse source: 0 = rising, 1 = falling, 2 = both.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- async_in  input  WIDTH  raw asynchronous inputs.
- sync_out  output  WIDTH  synchronized (not debounced) inputs.
- debounced  output  WIDTH  debounced level per channel.
- edge_pulse  output  WIDTH  one-cycle pulse per qualifying debounced edge.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Assertion clears every register immediately; release is sampled on clk.
- Reset values: all sync flops, sample counter, per-channel counters, the debounced-history register, sync_out, debounced and edge_pulse are 0.
- Synchronizer: per bit, a shift chain of SYNC_STAGES flops. sync_out is the last stage. Latency from async_in to sync_out is exactly SYNC_STAGES rising edges. No logic between stages.
- Sample counter:
  - Width $clog2(SAMPLE_CNT_MAX), minimum 1.
  - Counts 0..SAMPLE_CNT_MAX-1 and wraps to 0.
  - tick = (count == SAMPLE_CNT_MAX-1), combinational from the counter register.
  - SAMPLE_CNT_MAX = 1 gives tick on every cycle.
  - Free-running, identical for all channels.
- Per-channel saturating counter:
  - Width $clog2(PULSE_CNT_MAX+1).
  - If sync_out[i] == 0 in any cycle: next value is 0, regardless of tick.
  - Else if tick and count < PULSE_CNT_MAX: increment.
  - Else: hold. Saturates at PULSE_CNT_MAX and never wraps.
- debounced[i] = (count[i] == PULSE_CNT_MAX), decoded from the register (glitch-free).
  - Rise latency after sync_out rises: (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX+1 to PULSE_CNT_MAX*SAMPLE_CNT_MAX cycles, depending on tick phase.
  - Fall: 1 cycle after sync_out falls.
- Edge detector:
  - prev[i] registers debounced[i].
  - rise = debounced & ~prev; fall = ~debounced & prev.
  - edge_pulse is combinational from registers, per EDGE_MODE. Exactly one cycle wide.
  - EDGE_MODE values other than 0–2 behave as 0.
- Boundary conditions:
  - A glitch shorter than one sample interval that drops sync_out low clears the counter. Stability restarts from zero.
  - A tick coinciding with sync_out low gives count 0; clear wins.
  - Channels are fully independent except for the shared tick.
  - Reset asserted mid-count: all outputs go to 0 asynchronously, with no edge_pulse. After release, a held-high input must re-qualify from count 0.
- Arithmetic: unsigned only. No counter may overflow its declared width for any legal parameter set.

Test Plan:
- Bench parameters for all scenarios: WIDTH=2, SYNC_STAGES=3, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, EDGE_MODE=2.
- Reset state: hold rst_n=0 for 5 cycles with async_in=2'b11 -> sync_out, debounced and edge_pulse all 2'b00. After release, sync_out[0] goes 1 exactly 3 edges later.
- Clean press: async_in[0] 0->1 and held -> debounced[0] rises 9–12 cycles after sync_out[0] rises. edge_pulse[0]=1 for exactly one cycle, in the cycle debounced rises. Channel 1 stays 0.
- Bounce: async_in[0] high 6 cycles, low 1 cycle, high again -> counter restarts. debounced[0] rises only 9–12 cycles after the final sync_out rise; no early edge_pulse.
- Release: from debounced[0]=1, drop async_in[0] -> debounced[0]=0 at 4 cycles (3 sync + 1) after async_in falls. Falling edge_pulse[0] is one cycle; it occurs with EDGE_MODE=2 and is absent with EDGE_MODE=0.
- Independence: both channels pressed 2 cycles apart -> each debounces and pulses independently. Pulses never exceed one cycle, and no cross-channel effect occurs.
- Mid-operation reset: assert rst_n=0 while count[1]=2 -> all outputs 0 immediately. After release with input held high, debounced[1] needs a full 9–12 cycles after the new sync_out rise.
